// File: rtl/sram_pin_master.sv
// Host-side initiator for the 8-pin shared addr/data SRAM tile; turns byte write/read/burst requests into pin steps.
// Optional burst reads are compiled in with SRAM_MASTER_BURST_EN. Latency: write 6, read 2, burst first beat 4 cycles (HALF_PERIOD=1).
module sram_pin_master #(
  parameter int HALF_PERIOD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_burst,
  input  logic [2:0] req_addr,
  input  logic [2:0] req_len,
  input  logic [7:0] req_wdata,
  output logic       wr_done,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic [7:0] sram_pins,
  input  logic [7:0] sram_dout
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF_PERIOD - 1);

`ifdef SRAM_MASTER_BURST_EN
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, WR_CMT, RD, BST_SET, BST_RD} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, WR_CMT, RD} state_t;
`endif

  state_t          state_q, state_d;
  logic            phase_hi_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      addr_q;
  logic [7:0]      wdata_q;
  logic            ready_q;
  logic            wr_done_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_data_q;
  logic            rsp_last_q;
  logic            accept;
  logic            phase_end;
  logic            step_end;
  logic            rd_step;
  logic            last_beat;

`ifdef SRAM_MASTER_BURST_EN
  logic [2:0]      len_q;
  logic [2:0]      beat_q;
`else
  logic            unused_burst_fields;
  assign unused_burst_fields = ^{req_burst, req_len};
`endif

  assign req_ready = ready_q & ~reset;
  assign accept    = req_valid & req_ready;
  assign phase_end = (cnt_q == CNT_MAX);
  assign step_end  = phase_hi_q & phase_end;

`ifdef SRAM_MASTER_BURST_EN
  assign rd_step   = (state_q == RD) || (state_q == BST_RD);
  assign last_beat = (state_q == RD) || (beat_q == len_q);
`else
  assign rd_step   = (state_q == RD);
  assign last_beat = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_write) state_d = WR_LO;
`ifdef SRAM_MASTER_BURST_EN
          else if (req_burst) state_d = BST_SET;
`endif
          else state_d = RD;
        end
      end
      WR_LO:   if (step_end) state_d = WR_HI;
      WR_HI:   if (step_end) state_d = WR_CMT;
      WR_CMT:  if (step_end) state_d = IDLE;
      RD:      if (step_end) state_d = IDLE;
`ifdef SRAM_MASTER_BURST_EN
      BST_SET: if (step_end) state_d = BST_RD;
      BST_RD:  if (step_end && last_beat) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_hi_q  <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      wr_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
`ifdef SRAM_MASTER_BURST_EN
      len_q       <= '0;
      beat_q      <= '0;
`endif
    end else begin
      // Phase timing restarts from the low phase whenever we leave IDLE.
      if (state_q == IDLE) begin
        phase_hi_q <= 1'b0;
        cnt_q      <= '0;
      end else if (phase_end) begin
        phase_hi_q <= ~phase_hi_q;
        cnt_q      <= '0;
      end else begin
        cnt_q      <= cnt_q + 1'b1;
      end
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
`ifdef SRAM_MASTER_BURST_EN
        len_q   <= req_len;
        beat_q  <= '0;
`endif
      end
`ifdef SRAM_MASTER_BURST_EN
      if (state_q == BST_RD && step_end) beat_q <= beat_q + 1'b1;
`endif
      // Ready lags IDLE entry by a cycle so every request is separated by an all-zero pin cycle.
      ready_q     <= (state_q == IDLE) && !accept;
      wr_done_q   <= (state_q == WR_CMT) && step_end;
      rsp_valid_q <= rd_step && step_end;
      rsp_last_q  <= rd_step && step_end && last_beat;
      if (rd_step && step_end) rsp_data_q <= sram_dout;
    end
  end

  assign wr_done   = wr_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

  // sram_pins: [0] pin clk, [1] we, [2] oe, [3] commit, [7:4] nibble
  always_comb begin
    sram_pins = 8'h00;
    case (state_q)
      WR_LO:   sram_pins = {wdata_q[3:0], 3'b001, phase_hi_q};
      WR_HI:   sram_pins = {wdata_q[7:4], 3'b001, phase_hi_q};
      WR_CMT:  sram_pins = {1'b0, addr_q, 3'b100, phase_hi_q};
      RD:      sram_pins = {1'b0, addr_q, 3'b010, phase_hi_q};
`ifdef SRAM_MASTER_BURST_EN
      BST_SET: sram_pins = {1'b0, addr_q, 3'b111, phase_hi_q};
      BST_RD:  sram_pins = {4'h0, 3'b011, phase_hi_q};
`endif
      default: sram_pins = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_sram_pin_master.sv
// Directed bench for sram_pin_master: HALF_PERIOD=1 and HALF_PERIOD=3 instances, each with a behavioural pin-level tile.
// Burst checks run when SRAM_MASTER_BURST_EN is defined, otherwise the burst-ignored checks run.
module tb_sram_pin_master;

  logic       clk;
  logic       reset;

  logic       req_valid, req_write, req_burst;
  logic [2:0] req_addr, req_len;
  logic [7:0] req_wdata;
  logic       req_ready, wr_done, rsp_valid, rsp_last;
  logic [7:0] rsp_data, pins, dout;

  logic       req_valid1;
  logic [2:0] req_addr1;
  logic       req_ready1, wr_done1, rsp_valid1, rsp_last1;
  logic [7:0] rsp_data1, pins1, dout1;

  int n_cmp = 0;
  int n_err = 0;

  sram_pin_master #(.HALF_PERIOD(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_burst(req_burst), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .wr_done(wr_done), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .sram_pins(pins), .sram_dout(dout)
  );

  sram_pin_master #(.HALF_PERIOD(3)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(1'b0), .req_burst(1'b0), .req_addr(req_addr1), .req_len(3'd0),
    .req_wdata(8'h00), .wr_done(wr_done1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .rsp_last(rsp_last1), .sram_pins(pins1), .sram_dout(dout1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tile models: capture on each pin-clock rise, decoded by {commit, oe, we}.
  logic [7:0] mem0 [8];
  logic [7:0] wbuf0;
  logic [2:0] idx0;
  logic       pclk0_q = 1'b0;
  logic [7:0] mem1 [8];
  logic       pclk1_q = 1'b0;

  always @(negedge clk) begin
    pclk0_q <= pins[0];
    if (pins[0] && !pclk0_q) begin
      case (pins[3:1])
        3'b001: wbuf0 <= {pins[7:4], wbuf0[7:4]};
        3'b100: mem0[pins[6:4]] <= wbuf0;
        3'b010: dout <= mem0[pins[6:4]];
        3'b111: idx0 <= pins[6:4];
        3'b011: begin dout <= mem0[idx0]; idx0 <= idx0 + 3'd1; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    pclk1_q <= pins1[0];
    if (pins1[0] && !pclk1_q && pins1[3:1] == 3'b010) dout1 <= mem1[pins1[6:4]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", req_ready, 1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    wait_ready();
    req_write = 1'b1; req_burst = 1'b0; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!wr_done && n < 50) begin @(negedge clk); n++; end
    chk("wr_done_seen", wr_done, 1);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [2:0] a, output logic [7:0] d, output logic l);
    int n = 0;
    wait_ready();
    req_write = 1'b0; req_burst = 1'b0; req_addr = a; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("rsp_valid_seen", rsp_valid, 1);
    d = rsp_data;
    l = rsp_last;
    @(negedge clk);
  endtask

  logic [7:0] wexp [6];
  logic [7:0] hexp [7];
  logic [7:0] rd_d;
  logic       rd_l;
  int         cnt;

  initial begin
    wexp = '{8'h73, 8'hA2, 8'hA3, 8'h58, 8'h59, 8'h00};
    hexp = '{8'h24, 8'h24, 8'h24, 8'h25, 8'h25, 8'h25, 8'h00};
    for (int i = 0; i < 8; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    mem1[2] = 8'h3C;
    wbuf0 = 8'h00; idx0 = 3'd0; dout = 8'h00; dout1 = 8'h00;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_burst = 1'b0;
    req_addr = 3'd0; req_len = 3'd0; req_wdata = 8'h00;
    req_valid1 = 1'b0; req_addr1 = 3'd0;

    // Reset state
    cyc(3);
    chk("rst_ready", req_ready, 0);
    chk("rst_pins", pins, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_pins1", pins1, 0);
    reset = 1'b0;
    chk("ready_low_at_release", req_ready, 0);
    cyc(1);
    chk("ready_after_release", req_ready, 1);
    chk("ready1_after_release", req_ready1, 1);

    // HALF_PERIOD=3 single read: pin clk high 3 cycles, response 6 cycles after acceptance
    req_addr1 = 3'd2; req_valid1 = 1'b1;
    cyc(1);
    req_valid1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("hp3_pins", pins1, hexp[i]);
      chk("hp3_rsp_valid", rsp_valid1, (i == 6) ? 1 : 0);
      if (i < 6) cyc(1);
    end
    chk("hp3_rsp_data", rsp_data1, 8'h3C);
    chk("hp3_rsp_last", rsp_last1, 1);

    // Write 0xA7 to addr 5 with req_burst also set; a read request stays valid behind it
    wait_ready();
    req_write = 1'b1; req_burst = 1'b1; req_len = 3'd7; req_addr = 3'd5; req_wdata = 8'hA7;
    req_valid = 1'b1;
    cyc(1);
    chk("wr_pins_lo_low", pins, 8'h72);
    chk("wr_ready_busy", req_ready, 0);
    req_write = 1'b0; req_burst = 1'b0; req_len = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("wr_pins", pins, wexp[i]);
      chk("wr_ready_busy", req_ready, 0);
      chk("wr_no_rsp", rsp_valid, 0);
      chk("wr_done_timing", wr_done, (i == 5) ? 1 : 0);
    end
    cyc(1);
    chk("wr_ready_back", req_ready, 1);
    chk("wr_idle_pins", pins, 0);
    chk("wr_done_pulse", wr_done, 0);
    cyc(1);
    req_valid = 1'b0;
    chk("rd_pins_low", pins, 8'h54);
    chk("rd_ready_busy", req_ready, 0);
    cyc(1);
    chk("rd_pins_high", pins, 8'h55);
    chk("rd_no_rsp_yet", rsp_valid, 0);
    cyc(1);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 8'hA7);
    chk("rd_rsp_last", rsp_last, 1);
    chk("rd_idle_pins", pins, 0);

    for (int i = 0; i < 8; i++) do_write(3'(i), 8'((i + 1) * 17));

`ifdef SRAM_MASTER_BURST_EN
    // Burst from addr 6, four beats, wrapping through 7 -> 0
    wait_ready();
    req_write = 1'b0; req_burst = 1'b1; req_len = 3'd3; req_addr = 3'd6; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    chk("bst_set_low", pins, 8'h6E);
    cyc(1);
    chk("bst_set_high", pins, 8'h6F);
    cyc(1);
    chk("bst_rd_low", pins, 8'h06);
    cyc(1);
    chk("bst_rd_high", pins, 8'h07);
    chk("bst_no_rsp_yet", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("bst_beat_valid", rsp_valid, 1);
      chk("bst_beat_data", rsp_data, (i == 0) ? 8'h77 : (i == 1) ? 8'h88 : (i == 2) ? 8'h11 : 8'h22);
      chk("bst_beat_last", rsp_last, (i == 3) ? 1 : 0);
      if (i < 3) begin
        cyc(1);
        chk("bst_gap", rsp_valid, 0);
      end
    end
    cyc(1);
    chk("bst_done", rsp_valid, 0);
    chk("bst_idle_pins", pins, 0);
`else
    // Without burst support a burst request is a single read
    wait_ready();
    req_write = 1'b0; req_burst = 1'b1; req_len = 3'd7; req_addr = 3'd3; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    chk("nb_pins_low", pins, 8'h34);
    cyc(2);
    chk("nb_rsp_valid", rsp_valid, 1);
    chk("nb_rsp_data", rsp_data, 8'h44);
    chk("nb_rsp_last", rsp_last, 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (rsp_valid) cnt++;
    end
    chk("nb_single_rsp", cnt, 0);
    req_burst = 1'b0; req_len = 3'd0;
`endif

    // Reset during WR_HI leaves the old byte in place
    do_write(3'd1, 8'h99);
    wait_ready();
    req_write = 1'b1; req_burst = 1'b0; req_addr = 3'd1; req_wdata = 8'h55; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    cyc(2);
    chk("abort_wr_hi_pins", pins, 8'h52);
    reset = 1'b1;
    cyc(1);
    chk("abort_pins", pins, 0);
    chk("abort_ready", req_ready, 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_done) cnt++;
      cyc(1);
    end
    chk("abort_no_wr_done", cnt, 0);
    do_read(3'd1, rd_d, rd_l);
    chk("abort_mem_kept", rd_d, 8'h99);
    chk("abort_read_last", rd_l, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
